// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline (master) and hazard_ctrl (slave).
// HAZARD_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_tkn;
    logic                  imem_ready;
    logic                  dmem_busy;

    logic                  pc_freeze;
    logic                  ifid_freeze;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic [1:0]            state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]           stall_cnt;
    logic [31:0]           flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_branch_tkn, imem_ready, dmem_busy,
        input  pc_freeze, ifid_freeze, ifid_flush, idex_flush, state_o,
               stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_branch_tkn, imem_ready, dmem_busy,
        output pc_freeze, ifid_freeze, ifid_flush, idex_flush, state_o,
               stall_cnt, flush_cnt
    );
`else
    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_branch_tkn, imem_ready, dmem_busy,
        input  pc_freeze, ifid_freeze, ifid_flush, idex_flush, state_o
    );
    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_branch_tkn, imem_ready, dmem_busy,
        output pc_freeze, ifid_freeze, ifid_flush, idex_flush, state_o
    );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: freeze/flush of PC, IF/ID and ID/EX for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds free-running stall and flush cycle counters.
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        BR_FLUSH  = 2'd1,
        IF_WAIT   = 2'd2,
        MEM_STALL = 2'd3
    } state_e;

    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d, eval_state;
    logic [1:0] cnt_q, cnt_d;
    logic       load_use, take_branch;
    logic       pc_freeze, ifid_freeze, ifid_flush, idex_flush;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != {REG_ADDR_W{1'b0}}) &&
                      ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        take_branch = 1'b0;
        pc_freeze   = 1'b0;
        ifid_freeze = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;

        // A released memory stall is handled by the RUN rules in the same cycle.
        eval_state = (state_q == MEM_STALL && !hz.dmem_busy) ? RUN : state_q;

        unique case (eval_state)
            RUN: begin
                state_d = RUN;
                if (hz.dmem_busy) begin
                    pc_freeze   = 1'b1;
                    ifid_freeze = 1'b1;
                    state_d     = MEM_STALL;
                end else if (hz.ex_branch_tkn) begin
                    take_branch = 1'b1;
                end else if (load_use) begin
                    pc_freeze   = 1'b1;
                    ifid_freeze = 1'b1;
                    idex_flush  = 1'b1;
                end else if (!hz.imem_ready) begin
                    pc_freeze  = 1'b1;
                    ifid_flush = 1'b1;
                    state_d    = IF_WAIT;
                end
            end
            BR_FLUSH: begin
                if (hz.dmem_busy) begin
                    pc_freeze   = 1'b1;
                    ifid_freeze = 1'b1;
                end else if (hz.ex_branch_tkn) begin
                    take_branch = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                    cnt_d      = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = RUN;
                end
            end
            IF_WAIT: begin
                if (hz.dmem_busy) begin
                    pc_freeze   = 1'b1;
                    ifid_freeze = 1'b1;
                    state_d     = MEM_STALL;
                end else if (hz.ex_branch_tkn) begin
                    take_branch = 1'b1;
                end else if (!hz.imem_ready) begin
                    pc_freeze  = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_STALL: begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (take_branch) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            cnt_d      = CNT_INIT;
            state_d    = (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset silences every output at once, aborting any pending flush or wait.
    assign hz.pc_freeze   = pc_freeze && !rst;
    assign hz.ifid_freeze = ifid_freeze && !rst;
    assign hz.ifid_flush  = ifid_flush && !ifid_freeze && !rst;
    assign hz.idex_flush  = idex_flush && !rst;
    assign hz.state_o     = rst ? 2'd0 : state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (pc_freeze) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ifid_flush && !ifid_freeze) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a priority-list model of the pipeline sequencer.
module tb_hazard_ctrl;
    localparam int FC = 2;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       mr;
        logic       br;
        logic       ir;
        logic       busy;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    // Model: remaining branch-flush cycles, fetch-wait flag, memory-stall flag.
    int   m_flush_left = 0;
    bit   m_if_wait = 1'b0;
    bit   m_mem_stall = 1'b0;
    int   m_stall_cnt = 0;
    int   m_flush_cnt = 0;

    hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

    hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(FC)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
    );

    always #5 clk = ~clk;

    logic [5:0] outs;
    assign outs = {hz.state_o, hz.pc_freeze, hz.ifid_freeze, hz.ifid_flush, hz.idex_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, compare 1ns later, then advance the model.
    task automatic step(input logic r, input stim_t s, input string tag);
        logic pf, fz, fl, xf, lu;
        logic [1:0] es;
        int  nl;
        bit  nw, nm;
        @(negedge clk);
        rst              = r;
        hz.id_rs1        = s.rs1;
        hz.id_rs2        = s.rs2;
        hz.ex_rd         = s.rd;
        hz.id_rs1_used   = s.u1;
        hz.id_rs2_used   = s.u2;
        hz.ex_mem_read   = s.mr;
        hz.ex_branch_tkn = s.br;
        hz.imem_ready    = s.ir;
        hz.dmem_busy     = s.busy;
        #1;
        pf = 1'b0; fz = 1'b0; fl = 1'b0; xf = 1'b0;
        lu = s.mr && (s.rd != 5'd0) &&
             ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        es = r ? 2'd0 : (m_flush_left > 0) ? 2'd1 : m_if_wait ? 2'd2 : m_mem_stall ? 2'd3 : 2'd0;
        nl = m_flush_left; nw = m_if_wait; nm = 1'b0;
        if (r) begin
            nl = 0; nw = 1'b0;
        end else if (s.busy) begin
            pf = 1'b1; fz = 1'b1;
            if (m_flush_left == 0) begin nm = 1'b1; nw = 1'b0; end
        end else if (s.br) begin
            fl = 1'b1; xf = 1'b1; nl = FC - 1; nw = 1'b0;
        end else if (m_flush_left > 0) begin
            fl = 1'b1; nl = m_flush_left - 1;
        end else if (m_if_wait) begin
            if (!s.ir) begin pf = 1'b1; fl = 1'b1; end
            else nw = 1'b0;
        end else if (lu) begin
            pf = 1'b1; fz = 1'b1; xf = 1'b1;
        end else if (!s.ir) begin
            pf = 1'b1; fl = 1'b1; nw = 1'b1;
        end
        check(tag, 32'(outs), 32'({es, pf, fz, fl, xf}));
`ifdef HAZARD_PERF_CNT_EN
        check({tag, "_stall_cnt"}, hz.stall_cnt, 32'(m_stall_cnt));
        check({tag, "_flush_cnt"}, hz.flush_cnt, 32'(m_flush_cnt));
`endif
        if (r) begin
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            m_stall_cnt += int'(pf);
            m_flush_cnt += int'(fl);
        end
        m_flush_left = nl; m_if_wait = nw; m_mem_stall = nm;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ir = 1'b1;
        return s;
    endfunction

    initial begin
        stim_t s;
        logic  r;
        // Reset held two cycles with every input high.
        s = '1;
        hz.id_rs1 = '1; hz.id_rs2 = '1; hz.ex_rd = '1;
        hz.id_rs1_used = 1'b1; hz.id_rs2_used = 1'b1; hz.ex_mem_read = 1'b1;
        hz.ex_branch_tkn = 1'b1; hz.imem_ready = 1'b1; hz.dmem_busy = 1'b1;
        @(posedge clk);
        step(1'b1, s, "reset0");
        step(1'b1, s, "reset1");
        check("reset_outs", 32'(outs), 32'd0);
        step(1'b0, idle(), "post_reset");
        check("post_reset_outs", 32'(outs), 32'd0);

        // Load-use on rs2, then the load moves on.
        s = idle(); s.mr = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
        step(1'b0, s, "lu_hit");
        check("lu_hit_const", 32'(outs), 32'b00_1101);
        s.mr = 1'b0;
        step(1'b0, s, "lu_clear");
        check("lu_clear_const", 32'(outs), 32'd0);

        // Load to x0 never stalls.
        s = idle(); s.mr = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1;
        step(1'b0, s, "lu_x0");
        check("lu_x0_const", 32'(outs), 32'd0);

        // Taken branch with two flush cycles.
        s = idle(); s.br = 1'b1;
        step(1'b0, s, "br0");
        check("br0_const", 32'(outs), 32'b00_0011);
        step(1'b0, idle(), "br1");
        check("br1_const", 32'(outs), 32'b01_0010);
        step(1'b0, idle(), "br2");
        check("br2_const", 32'(outs), 32'd0);

        // Three cycles of fetch wait, then release.
        s = idle(); s.ir = 1'b0;
        step(1'b0, s, "ifw0");
        check("ifw0_const", 32'(outs), 32'b00_1010);
        step(1'b0, s, "ifw1");
        check("ifw1_const", 32'(outs), 32'b10_1010);
        step(1'b0, s, "ifw2");
        check("ifw2_const", 32'(outs), 32'b10_1010);
        step(1'b0, idle(), "ifw_rel");
        check("ifw_rel_const", 32'(outs), 32'b10_0000);
        step(1'b0, idle(), "ifw_run");
        check("ifw_run_const", 32'(outs), 32'd0);

        // Memory busy during branch flush with a simultaneous load-use.
        s = idle(); s.br = 1'b1;
        step(1'b0, s, "brm0");
        s = idle(); s.busy = 1'b1; s.mr = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1;
        step(1'b0, s, "brm_busy0");
        check("brm_busy0_const", 32'(outs), 32'b01_1100);
        step(1'b0, s, "brm_busy1");
        check("brm_busy1_const", 32'(outs), 32'b01_1100);
        step(1'b0, idle(), "brm_resume");
        check("brm_resume_const", 32'(outs), 32'b01_0010);
        step(1'b0, idle(), "brm_done");
        check("brm_done_const", 32'(outs), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        // Since post_reset: stall = lu_hit + ifw0..2 + 2 busy = 6; flush = br0,br1,ifw0..2,brm0,brm_resume = 7.
        check("perf_stall_exact", hz.stall_cnt, 32'd6);
        check("perf_flush_exact", hz.flush_cnt, 32'd7);
`endif

        // Randomized traffic with small register indices to provoke load-use.
        for (int i = 0; i < 3000; i++) begin
            s.rs1  = 5'($urandom_range(0, 3));
            s.rs2  = 5'($urandom_range(0, 3));
            s.rd   = 5'($urandom_range(0, 3));
            s.u1   = 1'($urandom_range(0, 1));
            s.u2   = 1'($urandom_range(0, 1));
            s.mr   = ($urandom_range(0, 99) < 40);
            s.br   = ($urandom_range(0, 99) < 10);
            s.ir   = ($urandom_range(0, 99) >= 20);
            s.busy = ($urandom_range(0, 99) < 15);
            r      = ($urandom_range(0, 99) < 2);
            step(r, s, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
